fft_stage_sdf: RTL and testbench

//  Generic radix-2 single-path delay-feedback (SDF) FFT stage for STAGE >= 2.

---
 rtl/fft_stage_sdf.sv | 142 ++++++++++++++
 tb/tb_fft_stage_sdf.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sdf.sv
// Radix-2 single-path delay-feedback FFT stage (STAGE >= 2) with a HALF_STEP-deep feedback buffer.
// Latency: a sample's result leaves HALF_STEP valid samples later, plus one register.
// Backpressure: none; in_valid gaps freeze all state, and out_valid drops for the gap cycles.
module fft_stage_sdf #(
  parameter int N          = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STAGE      = 2,
  parameter int QBITS      = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [0:1][DATA_WIDTH-1:0]        din,
  input  logic                              in_valid,
  output logic [$clog2(N)-2:0]              tw_idx,
  input  logic [0:1][DATA_WIDTH-1:0]        w,
  output logic [0:1][DATA_WIDTH-1:0]        dout,
  output logic                              out_valid
);

  localparam int LOGN = $clog2(N);
  localparam int STEP = 1 << STAGE;
  localparam int HALF = STEP / 2;
  localparam int BW   = STAGE - 1;       // buffer address width, HALF = 2**BW
  localparam int TWW  = LOGN - 1;        // twiddle index width
  localparam int PW   = 2 * DATA_WIDTH;  // full product width

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  // Sample counter and decode
  logic [LOGN-1:0] cnt;
  logic            upper;
  logic [BW-1:0]   baddr;
  logic [TWW-1:0]  baddr_ext;
  logic            primed;

  // Feedback buffer and datapath
  cplx_t fb_mem [HALF];
  cplx_t din_c;
  cplx_t w_c;
  cplx_t in1;
  cplx_t prod;
  cplx_t out1;
  cplx_t out2;
  cplx_t dout_q;

  // Widened operands and raw products
  logic signed [PW-1:0] wr_x;
  logic signed [PW-1:0] wi_x;
  logic signed [PW-1:0] xr_x;
  logic signed [PW-1:0] xi_x;
  logic signed [PW-1:0] p_rr;
  logic signed [PW-1:0] p_ii;
  logic signed [PW-1:0] p_ri;
  logic signed [PW-1:0] p_ir;

  assign din_c = '{re: din[0], im: din[1]};
  assign w_c   = '{re: w[0],   im: w[1]};

  // First half of each step (pos < HALF) fills or drains the buffer; second half runs the butterfly.
  assign upper = ~cnt[STAGE-1];
  assign baddr = cnt[BW-1:0];

  // Twiddle index is baddr * (N/STEP); N/STEP is a power of two, so a shift does it.
  assign baddr_ext = TWW'(baddr);
  assign tw_idx    = baddr_ext << (LOGN - STAGE);

  assign in1 = fb_mem[baddr];

  // Complex multiply w * din; every real product is rounded by its own arithmetic shift.
  always_comb begin
    wr_x = PW'(w_c.re);
    wi_x = PW'(w_c.im);
    xr_x = PW'(din_c.re);
    xi_x = PW'(din_c.im);
    p_rr = wr_x * xr_x;
    p_ii = wi_x * xi_x;
    p_ri = wr_x * xi_x;
    p_ir = wi_x * xr_x;
    prod.re = DATA_WIDTH'(p_rr >>> QBITS) - DATA_WIDTH'(p_ii >>> QBITS);
    prod.im = DATA_WIDTH'(p_ri >>> QBITS) + DATA_WIDTH'(p_ir >>> QBITS);
  end

  // Butterfly sum and difference; both wrap at DATA_WIDTH with no saturation or scaling.
  always_comb begin
    out1.re = in1.re + prod.re;
    out1.im = in1.im + prod.im;
    out2.re = in1.re - prod.re;
    out2.im = in1.im - prod.im;
  end

  // Counter wraps naturally at N (power of two); primed latches at the first second-half sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      cnt <= cnt + LOGN'(1);
      if (!upper) begin
        primed <= 1'b1;
      end
    end
  end

  // Feedback buffer: first half stores the new sample, second half stores the difference term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HALF; i++) begin
        fb_mem[i] <= '0;
      end
    end else if (in_valid) begin
      if (upper) begin
        fb_mem[baddr] <= din_c;
      end else begin
        fb_mem[baddr] <= out2;
      end
    end
  end

  // Output register: first half emits the stored difference from the previous step, second half the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid & (primed | ~upper);
      if (in_valid) begin
        if (upper) begin
          dout_q <= in1;
        end else begin
          dout_q <= out1;
        end
      end
    end
  end

  assign dout[0] = dout_q.re;
  assign dout[1] = dout_q.im;

endmodule

// File: tb/tb_fft_stage_sdf.sv
module tb_fft_stage_sdf;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // STAGE=2 instance (w driven as constant 1.0) and STAGE=3 instance (w from a ROM)
  logic [0:1][31:0] din2 = '0;
  logic [0:1][31:0] w2;
  logic [0:1][31:0] dout2;
  logic [1:0]       tw2;
  logic             iv2 = 1'b0;
  logic             ov2;

  logic [0:1][31:0] din3 = '0;
  logic [0:1][31:0] w3;
  logic [0:1][31:0] dout3;
  logic [1:0]       tw3;
  logic             iv3 = 1'b0;
  logic             ov3;

  int checks = 0;
  int fails  = 0;

  // Model state: every valid input since reset, per instance
  longint xr [2][256];
  longint xi [2][256];
  int     n_in [2] = '{0, 0};
  logic        exp_v  [2] = '{1'b0, 1'b0};
  logic [31:0] exp_re [2] = '{32'd0, 32'd0};
  logic [31:0] exp_im [2] = '{32'd0, 32'd0};

  // Captured valid outputs for literal sequence checks
  logic [31:0] cap2_re [$];
  logic [31:0] cap2_im [$];
  logic [31:0] cap3_re [$];
  logic [31:0] cap3_im [$];
  logic [31:0] cap3_tw [$];

  always #5 clk = ~clk;

  fft_stage_sdf #(.N(8), .DATA_WIDTH(32), .STAGE(2), .QBITS(14)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .in_valid(iv2), .tw_idx(tw2), .w(w2),
    .dout(dout2), .out_valid(ov2)
  );

  fft_stage_sdf #(.N(8), .DATA_WIDTH(32), .STAGE(3), .QBITS(14)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .in_valid(iv3), .tw_idx(tw3), .w(w3),
    .dout(dout3), .out_valid(ov3)
  );

  // W_8^k in Q14
  function automatic void rom_lookup(input int j, output longint wr, output longint wi);
    case (j)
      0:       begin wr = 16384;  wi = 0;      end
      1:       begin wr = 11585;  wi = -11585; end
      2:       begin wr = 0;      wi = -16384; end
      default: begin wr = -11585; wi = -11585; end
    endcase
  endfunction

  assign w2[0] = 32'd16384;
  assign w2[1] = 32'd0;

  always_comb begin
    longint wr, wi;
    rom_lookup(int'(tw3), wr, wi);
    w3[0] = wr[31:0];
    w3[1] = wi[31:0];
  end

  // Result for input number m of the stream: pairs m and its partner HALF apart in the same step.
  function automatic void model_out(input int d, input int k, output logic [31:0] er, output logic [31:0] ei);
    int h, m, j, a, b;
    bit first;
    longint wr, wi, pr, pim, rr, ri;
    h = (d == 0) ? 2 : 4;
    m = k - h;
    j = m % h;
    if (d == 0) begin
      wr = 16384; wi = 0;
    end else begin
      rom_lookup(j * (8 / (2 * h)), wr, wi);
    end
    first = (m % (2 * h)) < h;
    a = first ? m : m - h;
    b = first ? m + h : m;
    pr  = ((wr * xr[d][b]) >>> 14) - ((wi * xi[d][b]) >>> 14);
    pim = ((wr * xi[d][b]) >>> 14) + ((wi * xr[d][b]) >>> 14);
    rr = first ? xr[d][a] + pr  : xr[d][a] - pr;
    ri = first ? xi[d][a] + pim : xi[d][a] - pim;
    er = rr[31:0];
    ei = ri[31:0];
  endfunction

  task automatic model_step(input int d, input logic v, input logic [31:0] re, input logic [31:0] im);
    int k;
    if (!v) begin
      exp_v[d] = 1'b0;
    end else begin
      k = n_in[d];
      xr[d][k] = longint'($signed(re));
      xi[d][k] = longint'($signed(im));
      n_in[d] = k + 1;
      if (k >= ((d == 0) ? 2 : 4)) begin
        exp_v[d] = 1'b1;
        model_out(d, k, exp_re[d], exp_im[d]);
      end else begin
        exp_v[d]  = 1'b0;
        exp_re[d] = 32'd0;
        exp_im[d] = 32'd0;
      end
    end
  endtask

  // Model update on every clock edge and on reset assertion
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        n_in[d] = 0; exp_v[d] = 1'b0; exp_re[d] = 32'd0; exp_im[d] = 32'd0;
      end
    end else begin
      model_step(0, iv2, din2[0], din2[1]);
      model_step(1, iv3, din3[0], din3[1]);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("s2 out_valid", 32'(ov2), 32'(exp_v[0]));
    chk("s2 dout.re", dout2[0], exp_re[0]);
    chk("s2 dout.im", dout2[1], exp_im[0]);
    chk("s2 tw_idx", 32'(tw2), 32'((n_in[0] % 2) * 2));
    chk("s3 out_valid", 32'(ov3), 32'(exp_v[1]));
    chk("s3 dout.re", dout3[0], exp_re[1]);
    chk("s3 dout.im", dout3[1], exp_im[1]);
    chk("s3 tw_idx", 32'(tw3), 32'(n_in[1] % 4));
    if (ov2) begin cap2_re.push_back(dout2[0]); cap2_im.push_back(dout2[1]); end
    if (ov3) begin cap3_re.push_back(dout3[0]); cap3_im.push_back(dout3[1]); end
    if (iv3 && !rst) cap3_tw.push_back(32'(tw3));
  end

  task automatic cmp_seq(input string nm, input logic [31:0] act [$], input logic [31:0] exp [$]);
    chk({nm, " count"}, 32'(act.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      chk($sformatf("%s[%0d]", nm, i), (i < act.size()) ? act[i] : 32'hDEAD_BEEF, exp[i]);
    end
  endtask

  task automatic push2(input logic [31:0] re, input logic [31:0] im);
    @(posedge clk); #1;
    iv2 = 1'b1; din2[0] = re; din2[1] = im;
  endtask

  task automatic push3(input logic [31:0] re, input logic [31:0] im);
    @(posedge clk); #1;
    iv3 = 1'b1; din3[0] = re; din3[1] = im;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      iv2 = 1'b0; iv3 = 1'b0; din2 = '0; din3 = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; iv2 = 1'b0; iv3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cap2_re.delete(); cap2_im.delete(); cap3_re.delete(); cap3_im.delete(); cap3_tw.delete();
  endtask

  task automatic frame1_s2();
    for (int i = 1; i <= 8; i++) push2(32'(i), 32'd0);
  endtask

  logic [31:0] lit1 [$];
  logic [31:0] lit4 [$];
  logic [31:0] zeros8 [$];
  logic [31:0] zeros16 [$];
  logic [31:0] lit_imp [$];
  logic [31:0] lit_tw [$];
  logic [31:0] lit_ovf [$];

  initial begin
    lit1    = '{32'd4, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd12, 32'd14, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    lit4    = {lit1, lit1};
    zeros8  = '{8{32'd0}};
    zeros16 = '{16{32'd0}};
    lit_imp = '{32'd1000, 32'd0, 32'd0, 32'd0, 32'd1000, 32'd0, 32'd0, 32'd0};
    lit_tw  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3};
    lit_ovf = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Contiguous frame plus two flush zeros
    frame1_s2();
    push2(0, 0); push2(0, 0);
    idle(3);
    cmp_seq("t1 re", cap2_re, lit1);
    cmp_seq("t1 im", cap2_im, zeros8);

    // Same frame with 3-cycle gaps after samples 1, 4 and 7
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      push2(32'(i), 32'd0);
      if (i == 1 || i == 4 || i == 7) idle(3);
    end
    push2(0, 0); push2(0, 0);
    idle(3);
    cmp_seq("t2 re", cap2_re, lit1);

    // STAGE=3 impulse, twiddles from ROM
    do_reset();
    push3(32'd1000, 32'd0);
    for (int i = 0; i < 11; i++) push3(0, 0);
    idle(3);
    cmp_seq("t3 re", cap3_re, lit_imp);
    cmp_seq("t3 im", cap3_im, zeros8);
    cmp_seq("t3 tw", cap3_tw, lit_tw);

    // Two back-to-back frames
    do_reset();
    frame1_s2();
    frame1_s2();
    push2(0, 0); push2(0, 0);
    idle(3);
    cmp_seq("t4 re", cap2_re, lit4);
    cmp_seq("t4 im", cap2_im, zeros16);

    // Reset after sample 5, then replay from the start
    do_reset();
    for (int i = 1; i <= 5; i++) push2(32'(i), 32'd0);
    do_reset();
    frame1_s2();
    push2(0, 0); push2(0, 0);
    idle(3);
    cmp_seq("t5 re", cap2_re, lit1);

    // Wrap on overflow
    do_reset();
    repeat (4) push2(32'h7FFF_FFFF, 32'd0);
    push2(0, 0); push2(0, 0);
    idle(3);
    cmp_seq("t6 re", cap2_re, lit_ovf);

    // Complex data through non-trivial twiddles, checked against the model every cycle
    do_reset();
    for (int i = 0; i < 8; i++) push3(32'(i * 1234 - 3000), 32'(-(i * 777) + 501));
    push3(32'(-20000), 32'd4321);
    push3(32'd99, 32'(-7));
    idle(2);
    push3(0, 0); push3(0, 0);
    idle(3);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
